// File: rtl/reset_sequencer.sv
// Staged reset release: stages come out of reset one at a time in index order.
// Each stage is held for HOLD_CYCLES and then awaited (ready or timeout) before the next one.
module reset_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int STG_W          = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  soft_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic [STG_W-1:0]      cur_stage,
    output logic                  done,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {S_SYNC, S_HOLD, S_WAIT, S_DONE} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STG_W-1:0] LAST_STG  = STG_W'(NUM_STAGES - 1);

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [STG_W-1:0]      stg, stg_n;
    logic [NUM_STAGES-1:0] srst, srst_n;
    logic                  done_q, done_n;
    logic                  terr, terr_n;
    logic                  sync1, sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= 1'b0;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_SYNC;
            cnt    <= '0;
            stg    <= '0;
            srst   <= '1;
            done_q <= 1'b0;
            terr   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            stg    <= stg_n;
            srst   <= srst_n;
            done_q <= done_n;
            terr   <= terr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        stg_n   = stg;
        srst_n  = srst;
        done_n  = done_q;
        terr_n  = terr;
        case (state)
            S_SYNC: begin
                cnt_n = '0;
                // Leave on the edge that clears the second synchronizer flop.
                if (!sync1 || !sync2) state_n = S_HOLD;
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    srst_n[stg] = 1'b0;
                    cnt_n       = '0;
                    state_n     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (stage_ready[stg] || cnt == TOUT_LAST) begin
                    if (!stage_ready[stg]) terr_n = 1'b1;
                    cnt_n = '0;
                    if (stg == LAST_STG) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end else begin
                        stg_n   = stg + 1'b1;
                        state_n = S_HOLD;
                    end
                end
            end
            S_DONE: begin
                cnt_n  = '0;
                srst_n = '0;
                done_n = 1'b1;
            end
            default: state_n = S_SYNC;
        endcase
        // Soft restart overrides any ready/timeout decision made above.
        if (soft_rst_req && state != S_SYNC) begin
            srst_n  = '1;
            done_n  = 1'b0;
            terr_n  = 1'b0;
            stg_n   = '0;
            cnt_n   = '0;
            state_n = S_HOLD;
        end
    end

    assign stage_rst   = srst;
    assign cur_stage   = stg;
    assign done        = done_q;
    assign timeout_err = terr;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: edge-indexed expectation table fed through a scoreboard.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       soft_rst_req;
    logic [3:0] stage_ready;
    logic [3:0] stage_rst;
    logic [1:0] cur_stage;
    logic       done;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         scn;
        int         edge_n;
        logic [3:0] srst;
        logic       dn;
        logic       te;
        logic [1:0] cs;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    reset_sequencer #(
        .NUM_STAGES    (4),
        .STG_W         (2),
        .HOLD_CYCLES   (16),
        .TIMEOUT_CYCLES(64),
        .CNT_W         (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .soft_rst_req(soft_rst_req),
        .stage_ready (stage_ready),
        .stage_rst   (stage_rst),
        .cur_stage   (cur_stage),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic void add(int scn, int e, logic [3:0] s, logic d, logic t, logic [1:0] c);
        vec_t v;
        v.scn = scn; v.edge_n = e; v.srst = s; v.dn = d; v.te = t; v.cs = c;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got {rst,done,terr,stage}=%b want %b", name, got, want);
        end
    endtask

    function automatic logic [7:0] outs();
        return {stage_rst, done, timeout_err, cur_stage};
    endfunction

    task automatic load(input int scn);
        foreach (tbl[i]) if (tbl[i].scn == scn) sb.push_back(tbl[i]);
    endtask

    task automatic do_reset(input logic [3:0] rdy);
        rst          = 1'b1;
        soft_rst_req = 1'b0;
        stage_ready  = rdy;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", outs(), 8'b1111_0_0_00);
        rst = 1'b0;
        cyc = 0;
    endtask

    // Runs n edges; chg_edge/soft_edge are the edge numbers at which the new
    // ready value / the soft request are sampled (0 = never).
    task automatic run(input int n, input int chg_edge, input logic [3:0] chg_val, input int soft_edge);
        vec_t v;
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].edge_n == cyc) begin
                v = sb.pop_front();
                check($sformatf("scn%0d_edge%0d", v.scn, v.edge_n), outs(),
                      {v.srst, v.dn, v.te, v.cs});
            end
            if (cyc + 1 == chg_edge) stage_ready = chg_val;
            soft_rst_req = (cyc + 1 == soft_edge);
        end
        while (sb.size() > 0) begin
            v = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL scn%0d_edge%0d: not reached within %0d edges", v.scn, v.edge_n, n);
        end
    endtask

    initial begin
        // Scenario 1: power-on, all ready high
        add(1,  1, 4'b1111, 0, 0, 0);
        add(1,  2, 4'b1111, 0, 0, 0);
        add(1, 17, 4'b1111, 0, 0, 0);
        add(1, 18, 4'b1110, 0, 0, 0);
        add(1, 19, 4'b1110, 0, 0, 1);
        add(1, 34, 4'b1110, 0, 0, 1);
        add(1, 35, 4'b1100, 0, 0, 1);
        add(1, 51, 4'b1100, 0, 0, 2);
        add(1, 52, 4'b1000, 0, 0, 2);
        add(1, 53, 4'b1000, 0, 0, 3);
        add(1, 69, 4'b0000, 0, 0, 3);
        add(1, 70, 4'b0000, 1, 0, 3);
        add(1, 72, 4'b0000, 1, 0, 3);
        // Scenario 2: stage 1 never ready -> timeout, then soft reset from done
        add(2,  35, 4'b1100, 0, 0, 1);
        add(2,  98, 4'b1100, 0, 0, 1);
        add(2,  99, 4'b1100, 0, 1, 2);
        add(2, 114, 4'b1100, 0, 1, 2);
        add(2, 115, 4'b1000, 0, 1, 2);
        add(2, 132, 4'b0000, 0, 1, 3);
        add(2, 133, 4'b0000, 1, 1, 3);
        add(2, 139, 4'b0000, 1, 1, 3);
        add(2, 140, 4'b1111, 0, 0, 0);
        add(2, 155, 4'b1111, 0, 0, 0);
        add(2, 156, 4'b1110, 0, 0, 0);
        // Scenario 4: stage 2 waiting when rst is reasserted
        add(4, 53, 4'b1000, 0, 0, 2);
        add(4, 60, 4'b1000, 0, 0, 2);
        // Scenario 5: soft request on the same edge as stage_ready[3] rising
        add(5, 69, 4'b0000, 0, 0, 3);
        add(5, 74, 4'b0000, 0, 0, 3);
        add(5, 75, 4'b1111, 0, 0, 0);
        add(5, 76, 4'b1111, 0, 0, 0);
        add(5, 90, 4'b1111, 0, 0, 0);
        add(5, 91, 4'b1110, 0, 0, 0);
        // Scenario 6: stage_ready[2] early, stage_ready[1] late (edge 40)
        add(6, 39, 4'b1100, 0, 0, 1);
        add(6, 40, 4'b1100, 0, 0, 2);
        add(6, 55, 4'b1100, 0, 0, 2);
        add(6, 56, 4'b1000, 0, 0, 2);
        add(6, 57, 4'b1000, 0, 0, 3);
        add(6, 73, 4'b0000, 0, 0, 3);
        add(6, 74, 4'b0000, 1, 0, 3);

        do_reset(4'b1011);
        load(4);
        run(60, 0, 4'b0000, 0);
        #2 rst = 1'b1;
        #1 check("async_rst", outs(), 8'b1111_0_0_00);

        do_reset(4'b1111);
        load(1);
        run(72, 0, 4'b0000, 0);

        do_reset(4'b1101);
        load(2);
        run(160, 0, 4'b0000, 140);

        do_reset(4'b0111);
        load(5);
        run(95, 75, 4'b1111, 75);

        do_reset(4'b1101);
        load(6);
        run(80, 40, 4'b1111, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
